hcf_scheduler: RTL
==================

Name: hcf_scheduler

Overview:
- Shares one sequential subtract-based HCF (GCD) engine among NREQ requesters.
- Each requester presents an operand pair on a valid/ready handshake.
- A round-robin arbiter grants one requester at a time; the engine performs one subtraction per cycle.
- The result is returned on a single valid/ready response channel, tagged with the requester ID and the iteration count. It sits between operand producers and any consumer needing HCF results.

Parameters:
- N, 8, operand/result width in bits.
- NREQ, 4, number of requesters (2..16).
- IDW, $clog2(NREQ), requester ID width.

Ports:
- clk  in  1  system clock; one clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high (one-hot or zero).
- req_a  in  NREQ*N  packed operand A; requester i at [i*N +: N].
- req_b  in  NREQ*N  packed operand B, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_hcf  out  N  HCF result.
- rsp_id  out  IDW  requester index that owns the result.
- rsp_iter  out  N  number of subtractions performed.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low, async): state=IDLE; rr pointer=0; rsp_valid=0; rsp_hcf=0; rsp_id=0; rsp_iter=0; busy=0; internal a/b/count=0; req_ready=0 while rst_n low. Any in-flight job is abandoned, with no response.
- States: IDLE, CALC, DONE.
- IDLE:
  - Grant = first requester with req_valid set, searching from the rr pointer upward with wrap.
  - req_ready[grant]=1 combinationally; all other bits are 0. With no valid requester, req_ready=0.
  - On handshake (valid&ready) at edge T: capture a, b and id; clear count; next state CALC; rr pointer <= id+1 mod NREQ.
- CALC, evaluated each cycle on registered a and b:
  - a==b: result a; go to DONE.
  - a==0: result b; go to DONE. b==0: result a; go to DONE. So gcd(0,0)=0 and the engine never hangs.
  - Otherwise the larger operand becomes larger minus smaller; count+1; stay in CALC.
- DONE:
  - rsp_valid=1; rsp_hcf, rsp_id and rsp_iter are registered and stay stable until rsp_ready.
  - On rsp_valid&rsp_ready, go to IDLE; rsp_valid deasserts the next cycle.
  - No request is accepted in DONE, so there is a one-cycle bubble between jobs.
- Latency: handshake at edge T with k subtractions gives rsp_valid high from edge T+2+k.
- Worst case: k = 2^N-2 for operands (2^N-1, 1).
- req_ready is 0 in CALC and DONE. Requesters must hold their operands stable while valid, and may not drop valid without a handshake.
- Width rules:
  - Subtraction is unsigned N-bit and never underflows, because the smaller operand is always subtracted from the larger.
  - count is N bits and cannot overflow, since k ≤ 2^N-2.
- Simultaneous events: new requests arriving during CALC or DONE wait; the grant is evaluated only in IDLE.
- Fairness: a requester that keeps req_valid high is served within NREQ jobs.

Decomposition:
- Shared package hcf_pkg holds:
  - state enum {IDLE, CALC, DONE};
  - the default width constants;
  - a function rr_pick(valid, ptr) returning the grant index plus a found flag.
- Sub-module hcf_iter_core: the registered a/b/count datapath.
  - Inputs: load, a_in, b_in.
  - Outputs: done, result, iter.
  - Reuses the subtract-until-equal algorithm, with the zero-operand guard added.
- hcf_scheduler contains the arbiter, the FSM and the response registers.

Test Plan:
- Single request, requester 2, (12,8), rsp_ready=1 → rsp_hcf=4, rsp_id=2, rsp_iter=2, rsp_valid first high at T+4, high for exactly 1 cycle.
- Zero operands (0,9), then (0,0), then (7,7) → results 9, 0, 7; rsp_iter=0 each; rsp_valid at T+2.
- All 4 requesters valid at once with (30,12), (18,27), (5,3), (64,48), held until accepted → responses in ID order 0,1,2,3 with HCF 6, 9, 1, 16. Re-asserting requester 0 afterwards is then served after requester 3.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE → rsp_* stable, req_ready all 0, busy=1. Releasing rsp_ready gives a response on that edge and return to IDLE.
- Worst case (255,1) at N=8 → rsp_hcf=1, rsp_iter=254, rsp_valid at T+256.
- Assert rst_n low mid-CALC → outputs zero immediately (async), no stale response after release, next request served normally starting from requester 0 priority.

Source files
------------

// File: rtl/hcf_pkg.sv
// Shared types and helpers for the HCF scheduler: FSM states, default widths and
// the round-robin pick function used by the arbiter.
package hcf_pkg;

  localparam int unsigned DefN    = 8;
  localparam int unsigned DefNreq = 4;
  localparam int unsigned MaxReq  = 16;
  localparam int unsigned MaxIdw  = 4;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  typedef struct packed {
    logic              found;
    logic [MaxIdw-1:0] idx;
  } pick_t;

  // First set bit of valid at or above ptr, wrapping modulo nreq.
  function automatic pick_t rr_pick(input logic [MaxReq-1:0] valid,
                                    input logic [MaxIdw-1:0] ptr,
                                    input int unsigned       nreq);
    pick_t         p;
    logic [MaxIdw:0] pos;
    p.found = 1'b0;
    p.idx   = '0;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      if (k < nreq && !p.found) begin
        pos = {1'b0, ptr} + (MaxIdw + 1)'(k);
        if (pos >= (MaxIdw + 1)'(nreq)) pos = pos - (MaxIdw + 1)'(nreq);
        if (valid[pos[MaxIdw-1:0]]) begin
          p.found = 1'b1;
          p.idx   = pos[MaxIdw-1:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/hcf_iter_core.sv
// Sequential subtract-until-equal HCF datapath, one subtraction per cycle, with a
// zero-operand guard so the loop always terminates.
module hcf_iter_core
  import hcf_pkg::*;
#(
  parameter int unsigned N = DefN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         done_o,
  output logic [N-1:0] result_o,
  output logic [N-1:0] iter_o
);

  logic [N-1:0] a_q, a_d, b_q, b_d, cnt_q, cnt_d, res_q, res_d;
  logic         done_q, done_d;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    done_d = done_q;
    if (load_i) begin
      a_d    = a_i;
      b_d    = b_i;
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (!done_q) begin
      // done is registered, so a finished job is visible one cycle after detection
      if (a_q == b_q || b_q == '0) begin
        done_d = 1'b1;
        res_d  = a_q;
      end else if (a_q == '0) begin
        done_d = 1'b1;
        res_d  = b_q;
      end else if (a_q > b_q) begin
        a_d   = a_q - b_q;
        cnt_d = cnt_q + N'(1);
      end else begin
        b_d   = b_q - a_q;
        cnt_d = cnt_q + N'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
      done_q <= done_d;
    end
  end

  assign done_o   = done_q;
  assign result_o = res_q;
  assign iter_o   = cnt_q;

endmodule

// File: rtl/hcf_scheduler.sv
// Round-robin front end sharing one HCF engine among NREQ requesters, with a
// registered, tagged valid/ready response channel.
module hcf_scheduler
  import hcf_pkg::*;
#(
  parameter int unsigned N    = DefN,
  parameter int unsigned NREQ = DefNreq,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [N-1:0]    rsp_hcf,
  output logic [IDW-1:0]  rsp_id,
  output logic [N-1:0]    rsp_iter,
  output logic            busy
);

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] cur_id_q, cur_id_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [N-1:0]   rsp_hcf_q, rsp_hcf_d, rsp_iter_q, rsp_iter_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;

  logic [N-1:0]   a_arr [NREQ];
  logic [N-1:0]   b_arr [NREQ];
  pick_t          pick;
  logic [IDW-1:0] grant;
  logic           hs;
  logic           core_done;
  logic [N-1:0]   core_result, core_iter;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*N +: N];
    assign b_arr[i] = req_b[i*N +: N];
  end

  always_comb begin
    pick  = rr_pick(MaxReq'(req_valid), MaxIdw'(rr_ptr_q), NREQ);
    grant = IDW'(32'(pick.idx) % NREQ);
    hs    = (state_q == StIdle) && pick.found;
    req_ready = '0;
    // Held low throughout reset even though the FSM already sits in idle.
    if (hs && rst_n) req_ready[grant] = 1'b1;
  end

  hcf_iter_core #(
    .N(N)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (hs),
    .a_i      (a_arr[grant]),
    .b_i      (b_arr[grant]),
    .done_o   (core_done),
    .result_o (core_result),
    .iter_o   (core_iter)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_id_d    = cur_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_hcf_d   = rsp_hcf_q;
    rsp_iter_d  = rsp_iter_q;
    rsp_id_d    = rsp_id_q;
    unique case (state_q)
      StIdle: begin
        if (hs) begin
          state_d  = StCalc;
          cur_id_d = grant;
          rr_ptr_d = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
        end
      end
      StCalc: begin
        if (core_done) begin
          state_d     = StDone;
          rsp_valid_d = 1'b1;
          rsp_hcf_d   = core_result;
          rsp_iter_d  = core_iter;
          rsp_id_d    = cur_id_q;
        end
      end
      StDone: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      cur_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hcf_q   <= '0;
      rsp_iter_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_id_q    <= cur_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hcf_q   <= rsp_hcf_d;
      rsp_iter_q  <= rsp_iter_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_hcf   = rsp_hcf_q;
  assign rsp_iter  = rsp_iter_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != StIdle);

endmodule
